// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned num_dig);
        return (num_dig > 1) ? $clog2(num_dig) : 1;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// DIGIT-bit combinational ripple adder, also exposing the carry into its MSB.
module add_sub_slice #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout  = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NUM_DIG = WIDTH / DIGIT;
    localparam int unsigned CW      = cnt_width(NUM_DIG);

    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_add_sub: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_last;

    add_sub_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // The A register doubles as the result shift register: each consumed
    // digit of A frees DIGIT bits at the top for the new sum digit.
    if (NUM_DIG == 1) begin : g_single
        assign w_a_next = w_sum;
        assign w_b_next = r_b;
    end else begin : g_multi
        assign w_a_next = {w_sum, r_a[WIDTH-1:DIGIT]};
        assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end

    assign w_last   = (r_cnt == CW'(NUM_DIG - 1));
    assign in_ready = (r_state == IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result    <= w_a_next;
                        r_cout      <= w_cout;
                        r_ovf       <= w_cout ^ w_c_msb;
                        r_zero      <= (w_a_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four parameterisations checked against an arithmetic model.
module tb_serial_add_sub;

    localparam int NI = 4;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        longint      acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [NI];
    logic        ir   [NI];
    logic        ordy [NI];
    logic        ov   [NI];
    logic        cin  [NI];
    logic        sub  [NI];
    logic        co   [NI];
    logic        vf   [NI];
    logic        zf   [NI];
    logic [15:0] a    [NI];
    logic [15:0] b    [NI];
    logic [15:0] res  [NI];
    logic [7:0]  res8;
    logic        prev_ov [NI];

    exp_t   q [NI][$];
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign res[3] = {8'h00, res8};

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[0]), .b(b[0]),
        .cin(cin[0]), .sub(sub[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .result(res[0]), .cout(co[0]), .ovf(vf[0]), .zero(zf[0]));

    serial_add_sub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[1]), .b(b[1]),
        .cin(cin[1]), .sub(sub[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .result(res[1]), .cout(co[1]), .ovf(vf[1]), .zero(zf[1]));

    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a[2]), .b(b[2]),
        .cin(cin[2]), .sub(sub[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .result(res[2]), .cout(co[2]), .ovf(vf[2]), .zero(zf[2]));

    serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a[3][7:0]), .b(b[3][7:0]),
        .cin(cin[3]), .sub(sub[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .result(res8), .cout(co[3]), .ovf(vf[3]), .zero(zf[3]));

    function automatic int w_of(int i);
        return (i == 3) ? 8 : 16;
    endfunction

    function automatic int nd_of(int i);
        case (i)
            0:       return 4;
            1:       return 16;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic exp_t mk(logic [15:0] r, logic c, logic v, logic z);
        exp_t e;
        e.res = r; e.c = c; e.v = v; e.z = z; e.acc = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(int w, logic [15:0] aa, logic [15:0] bb, logic ci, logic su);
        exp_t   e;
        longint md, ua, ub, full, sa, sb, s, c1;
        md   = longint'(1) << w;
        ua   = longint'(aa) & (md - 1);
        ub   = longint'(bb) & (md - 1);
        c1   = ci ? 1 : 0;
        full = su ? (ua - ub - c1) : (ua + ub + c1);
        e.res = 16'(full & (md - 1));
        e.c   = su ? (full >= 0) : (full >= md);
        sa    = (ua >= md / 2) ? ua - md : ua;
        sb    = (ub >= md / 2) ? ub - md : ub;
        s     = su ? (sa - sb - c1) : (sa + sb + c1);
        e.v   = (s >= md / 2) || (s < -(md / 2));
        e.z   = (e.res == 16'h0000);
        e.acc = 0;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(int i, logic [15:0] aa, logic [15:0] bb, logic ci, logic su,
                         bit use_lit, exp_t lit);
        exp_t e;
        int   n;
        @(negedge clk);
        a[i] = aa; b[i] = bb; cin[i] = ci; sub[i] = su; iv[i] = 1'b1;
        n = 0;
        while (!ir[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[i]) begin
            check($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
            iv[i] = 1'b0;
            return;
        end
        e = model(w_of(i), aa, bb, ci, su);
        if (use_lit) begin
            check("model_res", 32'(e.res), 32'(lit.res));
            check("model_cout", 32'(e.c), 32'(lit.c));
            check("model_ovf", 32'(e.v), 32'(lit.v));
            check("model_zero", 32'(e.z), 32'(lit.z));
            e = lit;
        end
        e.acc = cyc + 1;
        q[i].push_back(e);
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        a[i] = 16'($urandom); b[i] = 16'($urandom);
        cin[i] = 1'($urandom); sub[i] = 1'($urandom);
    endtask

    task automatic drain(int i);
        int n;
        n = 0;
        while (q[i].size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain%0d", i), 32'(q[i].size()), 32'd0);
    endtask

    task automatic sweep(int i);
        for (int k = 0; k < 1000; k++)
            issue(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0));
        drain(i);
    endtask

    // Compare every valid result cycle against the head expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                prev_ov[i] = 1'b0;
            end else if (ov[i]) begin
                if (q[i].size() == 0) begin
                    check($sformatf("unexpected_valid%0d", i), 32'd1, 32'd0);
                end else begin
                    e = q[i][0];
                    check($sformatf("result%0d", i), 32'(res[i]), 32'(e.res));
                    check($sformatf("cout%0d", i), 32'(co[i]), 32'(e.c));
                    check($sformatf("ovf%0d", i), 32'(vf[i]), 32'(e.v));
                    check($sformatf("zero%0d", i), 32'(zf[i]), 32'(e.z));
                    check($sformatf("in_ready_in_done%0d", i), 32'(ir[i]), 32'd0);
                    if (!prev_ov[i])
                        check($sformatf("latency%0d", i), 32'(cyc - e.acc),
                              32'(nd_of(i)));
                    if (ordy[i]) void'(q[i].pop_front());
                end
                prev_ov[i] = 1'b1;
            end else begin
                prev_ov[i] = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; a[i] = '0; b[i] = '0;
            cin[i] = 1'b0; sub[i] = 1'b0; prev_ov[i] = 1'b0;
        end
        #1;
        check("rst_in_ready", 32'(ir[0]), 32'd0);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_flags", {29'd0, co[0], vf[0], zf[0]}, 32'd0);
        check("rst_result", 32'(res[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(ir[0]), 32'd1);

        issue(0, 16'h1234, 16'h0FF0, 1'b0, 1'b0, 1'b1, mk(16'h2224, 1'b0, 1'b0, 1'b0));
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
        issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
        issue(0, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b1, mk(16'h000F, 1'b1, 1'b0, 1'b0));
        issue(3, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0080, 1'b0, 1'b1, 1'b0));
        issue(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
        issue(1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < NI; i++) drain(i);

        // Backpressure: result held while new operands sit on the input.
        @(negedge clk);
        ordy[0] = 1'b0;
        issue(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, mk(16'h0007, 1'b0, 1'b0, 1'b0));
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(ov[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            a[0] = 16'h1111; b[0] = 16'h2222; cin[0] = 1'b0; sub[0] = 1'b0; iv[0] = 1'b1;
            @(negedge clk);
            check("bp_hold_result", 32'(res[0]), 32'h0007);
            check("bp_hold_valid", 32'(ov[0]), 32'd1);
            check("bp_in_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, mk(16'h3333, 1'b0, 1'b0, 1'b0));
        drain(0);

        // Reset during the second RUN cycle aborts the operation.
        issue(0, 16'h00FF, 16'h0F00, 1'b0, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        q[0].delete();
        #1;
        check("abort_valid", 32'(ov[0]), 32'd0);
        check("abort_result", 32'(res[0]), 32'd0);
        check("abort_flags", {29'd0, co[0], vf[0], zf[0]}, 32'd0);
        check("abort_in_ready", 32'(ir[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_result", 32'(ov[0]), 32'd0);
        issue(0, 16'h0100, 16'h0023, 1'b1, 1'b0, 1'b1, mk(16'h0124, 1'b0, 1'b0, 1'b0));
        drain(0);

        fork
            sweep(0);
            sweep(1);
            sweep(2);
            sweep(3);
        join

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
